// File: rtl/spi_slave_regfile.sv
// SPI mode-0 target exposing a 2**ADDR_W x 8 register bank; all SPI pins are oversampled in CTRL_CLK.
// Optional: define SPI_REGFILE_ERR_EN to add FRAME_ERR and a sticky status register at the top address.
module spi_slave_regfile #(
  parameter int         ADDR_W    = 3,
  parameter logic [7:0] RESET_VAL = 8'h00
) (
  input  logic              CTRL_CLK,
  input  logic              RST,
  input  logic              CS,
  input  logic              SCLK,
  input  logic              SDI,
  output logic              SDO,
  output logic              SDO_OE,
  output logic              WR_STB,
  output logic [ADDR_W-1:0] WR_ADDR,
  output logic [7:0]        WR_DATA,
  output logic              RD_STB,
  output logic [7:0]        slave_stash_ptr,
  output logic              BUSY
`ifdef SPI_REGFILE_ERR_EN
  ,
  output logic              FRAME_ERR
`endif
);

  localparam int DEPTH = 1 << ADDR_W;

  localparam logic [2:0] ST_WAIT_CS = 3'd0;
  localparam logic [2:0] ST_IDLE    = 3'd1;
  localparam logic [2:0] ST_CMD     = 3'd2;
  localparam logic [2:0] ST_WR      = 3'd3;
  localparam logic [2:0] ST_RD      = 3'd4;

  logic [2:0]        state;
  logic [1:0]        cs_sync;
  logic [1:0]        sclk_sync;
  logic [1:0]        sdi_sync;
  logic              sclk_prev;
  logic [2:0]        bit_cnt;
  logic [6:0]        rx_shift;
  logic [7:0]        tx_shift;
  logic [ADDR_W-1:0] ptr;
  logic [7:0]        regs [DEPTH];
  logic              sdo_r;

  logic              cs_s;
  logic              sdi_s;
  logic              sclk_rise;
  logic              sclk_fall;
  logic              in_frame;
  logic              byte_done;
  logic [7:0]        rx_byte;
  logic [ADDR_W-1:0] ld_addr;
  logic [7:0]        ld_data;

`ifdef SPI_REGFILE_ERR_EN
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  logic err_sticky;
`endif

  assign cs_s      = cs_sync[1];
  assign sdi_s     = sdi_sync[1];
  assign sclk_rise = sclk_sync[1] & ~sclk_prev;
  assign sclk_fall = ~sclk_sync[1] & sclk_prev;
  assign in_frame  = (state == ST_CMD) || (state == ST_WR) || (state == ST_RD);
  assign byte_done = in_frame && sclk_rise && (bit_cnt == 3'd7);
  assign rx_byte   = {rx_shift, sdi_s};

  assign SDO_OE          = (state == ST_RD);
  assign SDO             = sdo_r & SDO_OE;
  assign BUSY            = in_frame;
  assign slave_stash_ptr = {{(8 - ADDR_W){1'b0}}, ptr};

  // The command byte loads from its own address field; later loads fetch the next register.
  always_comb begin
    ld_addr = (state == ST_CMD) ? rx_byte[ADDR_W-1:0] : ADDR_W'(ptr + 1'b1);
    ld_data = regs[ld_addr];
`ifdef SPI_REGFILE_ERR_EN
    if (ld_addr == LAST_ADDR) begin
      ld_data = {regs[LAST_ADDR][7:1], err_sticky};
    end
`endif
  end

  always_ff @(posedge CTRL_CLK or posedge RST) begin
    if (RST) begin
      cs_sync   <= '0;
      sclk_sync <= '0;
      sdi_sync  <= '0;
      sclk_prev <= 1'b0;
    end else begin
      cs_sync   <= {cs_sync[0], CS};
      sclk_sync <= {sclk_sync[0], SCLK};
      sdi_sync  <= {sdi_sync[0], SDI};
      sclk_prev <= sclk_sync[1];
    end
  end

  // Later assignments to state win, so a CS abort overrides a byte completing in the same cycle.
  always_ff @(posedge CTRL_CLK or posedge RST) begin
    if (RST) begin
      state    <= ST_WAIT_CS;
      bit_cnt  <= '0;
      rx_shift <= '0;
      tx_shift <= '0;
      ptr      <= '0;
      sdo_r    <= 1'b0;
      WR_STB   <= 1'b0;
      WR_ADDR  <= '0;
      WR_DATA  <= '0;
      RD_STB   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= RESET_VAL;
      end
`ifdef SPI_REGFILE_ERR_EN
      FRAME_ERR  <= 1'b0;
      err_sticky <= 1'b0;
`endif
    end else begin
      WR_STB <= 1'b0;
      RD_STB <= 1'b0;
`ifdef SPI_REGFILE_ERR_EN
      FRAME_ERR <= 1'b0;
`endif

      if (in_frame && sclk_rise) begin
        rx_shift <= rx_byte[6:0];
        bit_cnt  <= bit_cnt + 3'd1;
      end

      if ((state == ST_RD) && sclk_fall) begin
        sdo_r    <= tx_shift[7];
        tx_shift <= {tx_shift[6:0], 1'b0};
      end

      if (byte_done) begin
        case (state)
          ST_CMD: begin
            ptr <= rx_byte[ADDR_W-1:0];
            if (rx_byte[7]) begin
              tx_shift <= ld_data;
              RD_STB   <= 1'b1;
              state    <= ST_RD;
            end else begin
              state <= ST_WR;
            end
          end
          ST_WR: begin
`ifdef SPI_REGFILE_ERR_EN
            if (ptr == LAST_ADDR) begin
              err_sticky <= 1'b0;
            end else begin
              regs[ptr] <= rx_byte;
            end
`else
            regs[ptr] <= rx_byte;
`endif
            WR_STB  <= 1'b1;
            WR_ADDR <= ptr;
            WR_DATA <= rx_byte;
            ptr     <= ptr + 1'b1;
          end
          default: begin
            ptr      <= ptr + 1'b1;
            tx_shift <= ld_data;
            RD_STB   <= 1'b1;
          end
        endcase
      end

      case (state)
        ST_WAIT_CS: begin
          if (cs_s) begin
            state <= ST_IDLE;
          end
        end
        ST_IDLE: begin
          if (!cs_s) begin
            state   <= ST_CMD;
            bit_cnt <= '0;
          end
        end
        default: begin
          if (cs_s) begin
            state   <= ST_IDLE;
            bit_cnt <= '0;
            sdo_r   <= 1'b0;
`ifdef SPI_REGFILE_ERR_EN
            if ((state == ST_CMD) || ((bit_cnt != 3'd0) && !byte_done)) begin
              FRAME_ERR  <= 1'b1;
              err_sticky <= 1'b1;
            end
`endif
          end
        end
      endcase
    end
  end

endmodule
